// File: rtl/fp_add_normalize.sv
// Floating-point add/subtract and renormalise stage: adds the aligned mantissas,
// fixes a carry with one right shift and cancellation with one left shift per cycle.
module fp_add_normalize #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_of_great,
  input  logic              sign_of_small,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mantis_great,
  input  logic [MANT_W-1:0] mantis_small,
  input  logic              loss,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              res_sign,
  output logic [EXP_W-1:0]  res_exp,
  output logic [MANT_W-1:0] res_mantis,
  output logic              res_loss,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t state_reg, state_next;

  logic              sg_reg, sg_next;
  logic              ss_reg, ss_next;
  logic [EXP_W-1:0]  exp_reg, exp_next;
  logic [MANT_W-1:0] great_reg, great_next;
  logic [MANT_W-1:0] small_reg, small_next;
  logic              loss_reg, loss_next;

  logic              sign_reg, sign_next;
  logic [EXP_W-1:0]  rexp_reg, rexp_next;
  logic [MANT_W-1:0] mant_reg, mant_next;
  logic              rloss_reg, rloss_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic [MANT_W-1:0] sum;
  logic [EXP_W:0]    exp_inc;
  logic [MANT_W-1:0] shl_mant;
  logic [EXP_W-1:0]  shl_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sg_reg    <= 1'b0;
      ss_reg    <= 1'b0;
      exp_reg   <= '0;
      great_reg <= '0;
      small_reg <= '0;
      loss_reg  <= 1'b0;
      sign_reg  <= 1'b0;
      rexp_reg  <= '0;
      mant_reg  <= '0;
      rloss_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sg_reg    <= sg_next;
      ss_reg    <= ss_next;
      exp_reg   <= exp_next;
      great_reg <= great_next;
      small_reg <= small_next;
      loss_reg  <= loss_next;
      sign_reg  <= sign_next;
      rexp_reg  <= rexp_next;
      mant_reg  <= mant_next;
      rloss_reg <= rloss_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // great >= small is guaranteed upstream, so the subtraction never borrows.
  assign sum     = (sg_reg ^ ss_reg) ? (great_reg - small_reg) : (great_reg + small_reg);
  assign exp_inc = {1'b0, exp_reg} + {{EXP_W{1'b0}}, 1'b1};

  // One normalisation step; an exponent of 0 or 1 blocks further shifting.
  always_comb begin
    shl_mant = mant_reg;
    shl_exp  = rexp_reg;
    if (!mant_reg[MANT_W-2] && (rexp_reg > EXP_ONE)) begin
      shl_mant = {mant_reg[MANT_W-2:0], 1'b0};
      shl_exp  = rexp_reg - EXP_ONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    sg_next    = sg_reg;
    ss_next    = ss_reg;
    exp_next   = exp_reg;
    great_next = great_reg;
    small_next = small_reg;
    loss_next  = loss_reg;
    sign_next  = sign_reg;
    rexp_next  = rexp_reg;
    mant_next  = mant_reg;
    rloss_next = rloss_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sg_next    = sign_of_great;
          ss_next    = sign_of_small;
          exp_next   = exp;
          great_next = mantis_great;
          small_next = mantis_small;
          loss_next  = loss;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          state_next = ADD;
        end
      end
      ADD: begin
        sign_next  = sg_reg;
        rexp_next  = exp_reg;
        mant_next  = sum;
        rloss_next = loss_reg;
        if (sum == '0) begin
          sign_next  = 1'b0;
          rexp_next  = '0;
          state_next = DONE;
        end else if (sum[MANT_W-1]) begin
          mant_next  = {1'b0, sum[MANT_W-1:1]};
          rloss_next = loss_reg | sum[0];
          if (exp_inc >= EXP_MAX) begin
            rexp_next = {EXP_W{1'b1}};
            mant_next = '0;
            ovf_next  = 1'b1;
          end else begin
            rexp_next = exp_inc[EXP_W-1:0];
          end
          state_next = DONE;
        end else if (sum[MANT_W-2]) begin
          state_next = DONE;
        end else begin
          state_next = NORM;
        end
      end
      NORM: begin
        mant_next = shl_mant;
        rexp_next = shl_exp;
        if (shl_mant[MANT_W-2]) begin
          state_next = DONE;
        end else if (shl_exp <= EXP_ONE) begin
          rexp_next  = '0;
          unf_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign res_sign   = sign_reg;
  assign res_exp    = rexp_reg;
  assign res_mantis = mant_reg;
  assign res_loss   = rloss_reg;
  assign overflow   = ovf_reg;
  assign underflow  = unf_reg;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Randomised bench for fp_add_normalize: an arithmetic reference model predicts each
// result and its latency; a monitor compares every cycle the result is presented.
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_of_great = 1'b0;
  logic        sign_of_small = 1'b0;
  logic [7:0]  exp = '0;
  logic [25:0] mantis_great = '0;
  logic [25:0] mantis_small = '0;
  logic        loss = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [25:0] res_mantis;
  logic        res_loss;
  logic        overflow;
  logic        underflow;

  fp_add_normalize #(.EXP_W(8), .MANT_W(26)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_of_great(sign_of_great), .sign_of_small(sign_of_small), .exp(exp),
    .mantis_great(mantis_great), .mantis_small(mantis_small), .loss(loss),
    .out_valid(out_valid), .out_ready(out_ready), .res_sign(res_sign),
    .res_exp(res_exp), .res_mantis(res_mantis), .res_loss(res_loss),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [25:0] mant;
    logic        lss;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;   // 0 random, 1 held low, 2 held high
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: value arithmetic on integers, normalisation as a count of doublings.
  function automatic res_t model(input bit sg, input bit ss, input int e,
                                 input int g, input int s, input bit l);
    res_t r;
    int sum, k, allowed;
    sum = (sg ^ ss) ? g - s : g + s;
    r.sign = sg; r.e = 8'(e); r.mant = 26'(sum); r.lss = l;
    r.ovf = 0; r.unf = 0; r.lat = 1; r.acc = 0;
    if (sum == 0) begin
      r.sign = 0; r.e = 0; r.mant = 0;
    end else if (sum >= (1 << 25)) begin
      r.lss = l | (sum % 2 == 1);
      if (e + 1 >= 255) begin
        r.e = 8'd255; r.mant = 0; r.ovf = 1;
      end else begin
        r.e = 8'(e + 1); r.mant = 26'(sum / 2);
      end
    end else if (sum < (1 << 24)) begin
      k = 0;
      while ((sum << k) < (1 << 24)) k++;
      allowed = (e > 1) ? e - 1 : 0;
      if (k <= allowed) begin
        r.mant = 26'(sum << k); r.e = 8'(e - k); r.lat = 1 + k;
      end else begin
        r.mant = 26'(sum << allowed); r.e = 0; r.unf = 1;
        r.lat = 1 + ((allowed == 0) ? 1 : allowed);
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, q[0].lat);
          seen = 1;
        end
        chk("res_sign", res_sign, q[0].sign);
        chk("res_exp", res_exp, q[0].e);
        chk("res_mantis", res_mantis, q[0].mant);
        chk("res_loss", res_loss, q[0].lss);
        chk("overflow", overflow, q[0].ovf);
        chk("underflow", underflow, q[0].unf);
        chk("in_ready_in_done", in_ready, 0);
        $display("result sign=%0d exp=%0d mant=0x%07h loss=%0d ovf=%0d unf=%0d ready=%0d",
                 res_sign, res_exp, res_mantis, res_loss, overflow, underflow, out_ready);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  task automatic apply(input bit sg, input bit ss, input int e,
                       input int g, input int s, input bit l);
    int w = 0;
    res_t r;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    sign_of_great = sg; sign_of_small = ss; exp = 8'(e);
    mantis_great = 26'(g); mantis_small = 26'(s); loss = l;
    in_valid = 1'b1;
    r = model(sg, ss, e, g, s, l);
    r.acc = cyc + 1;
    $display("apply sg=%0d ss=%0d exp=%0d great=0x%07h small=0x%07h loss=%0d", sg, ss, e, g, s, l);
    @(posedge clk);
    q.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
    mantis_great = 26'($urandom);
    mantis_small = 26'($urandom);
  endtask

  task automatic directed(input string nm, input bit sg, input bit ss, input int e,
                          input int g, input int s, input bit l,
                          input int we, input int wm, input bit ws, input bit wl,
                          input bit wo, input bit wu, input int wlat);
    res_t r;
    r = model(sg, ss, e, g, s, l);
    chk({nm, "_model_exp"}, r.e, we);
    chk({nm, "_model_mant"}, r.mant, wm);
    chk({nm, "_model_sign"}, r.sign, ws);
    chk({nm, "_model_loss"}, r.lss, wl);
    chk({nm, "_model_ovf"}, r.ovf, wo);
    chk({nm, "_model_unf"}, r.unf, wu);
    chk({nm, "_model_lat"}, r.lat, wlat);
    apply(sg, ss, e, g, s, l);
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || !in_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", w < 100, 1);
  endtask

  initial begin
    int g, s, e, sh, d;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {res_sign, res_exp, res_mantis, res_loss, overflow, underflow}, 0);

    rdy_mode = 2;
    directed("one_plus_one", 0, 0, 127, 'h1000000, 'h1000000, 0, 128, 'h1000000, 0, 0, 0, 0, 1);
    directed("one_minus_075", 0, 1, 127, 'h1000000, 'h0C00000, 0, 125, 'h1000000, 0, 0, 0, 0, 3);
    directed("exact_cancel", 1, 0, 100, 'h1000000, 'h1000000, 0, 0, 0, 0, 0, 0, 0, 1);
    directed("overflow", 0, 0, 254, 'h1FFFFFE, 'h1FFFFFE, 0, 255, 0, 0, 0, 1, 0, 1);
    directed("carry_loss", 0, 0, 127, 'h1000001, 'h1000000, 0, 128, 'h1000000, 0, 1, 0, 0, 1);
    directed("underflow", 1, 0, 2, 'h1000000, 'h0C00000, 0, 0, 'h0800000, 1, 0, 0, 1, 2);
    drain();

    rdy_mode = 1;
    apply(0, 0, 127, 'h1000000, 'h1000000, 1);
    repeat (8) @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
    rdy_mode = 2;
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      g = (i % 5 == 0) ? int'($urandom % (1 << 25)) : ((1 << 24) | int'($urandom % (1 << 24)));
      case ($urandom % 3)
        0: s = int'($urandom % (g + 1));
        1: begin
          sh = int'($urandom_range(0, 24));
          d = int'($urandom % (1 << sh));
          s = g - ((d > g) ? g : d);
        end
        default: s = g >> $urandom_range(0, 25);
      endcase
      case ($urandom % 6)
        0: e = int'($urandom_range(0, 3));
        1: e = int'($urandom_range(250, 255));
        default: e = int'($urandom_range(0, 255));
      endcase
      apply(1'($urandom), 1'($urandom), e, g, s, 1'($urandom));
    end
    drain();

    // Reset during a 24-shift normalisation must abandon the operation.
    rdy_mode = 2;
    apply(0, 1, 127, 'h1000000, 'h0FFFFFF, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midnorm_rst_out_valid", out_valid, 0);
    chk("midnorm_rst_in_ready", in_ready, 1);
    chk("midnorm_rst_outputs", {res_sign, res_exp, res_mantis, res_loss, overflow, underflow}, 0);

    apply(0, 0, 10, 'h1800000, 'h0800000, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
